// File: rtl/dma_pkg.sv
// Shared types and helpers for the tile-moving DMA: controller states,
// transfer direction encodings and the element-lane width calculation.
package dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_REQ = 3'd1,
        S_UNPACK = 3'd2,
        S_ST_RD  = 3'd3,
        S_ST_CAP = 3'd4,
        S_WR_REQ = 3'd5,
        S_DONE   = 3'd6
    } dma_state_t;

    localparam logic DIR_LOAD  = 1'b0;
    localparam logic DIR_STORE = 1'b1;

    // Floor log2 of the elements-per-word count (exact for powers of two).
    function automatic int log2_pack(input int pack);
        int r;
        r = 0;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) <= pack) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Tile address walker: x fastest, then y (row stride), then f (channel
// stride), producing the element address, dense buffer address and lane.
module dma_addr_gen
    import dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 16,
    parameter int DIM_W  = 8,
    parameter int CH_W   = 11,
    parameter int PACK   = 2,
    parameter int LANE_W = (log2_pack(PACK) > 0) ? log2_pack(PACK) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_step,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_stride_y,
    input  logic [ADDR_W-1:0] i_stride_f,
    input  logic [DIM_W-1:0]  i_len_x,
    input  logic [DIM_W-1:0]  i_len_y,
    input  logic [CH_W-1:0]   i_len_f,
    input  logic [RAM_AW-1:0] i_ram_base,
    output logic [ADDR_W-1:0] o_elem,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic              o_last,
    output logic              o_same_word,
    output logic [LANE_W-1:0] o_lane
);

    logic [DIM_W-1:0]  r_len_x, r_len_y, r_x, r_y;
    logic [CH_W-1:0]   r_len_f, r_f;
    logic [ADDR_W-1:0] r_stride_y, r_stride_f;
    logic [ADDR_W-1:0] r_elem, r_row, r_plane;
    logic [RAM_AW-1:0] r_ram_addr;
    logic              w_x_last, w_y_last;

    assign w_x_last    = (r_x == (r_len_x - DIM_W'(1)));
    assign w_y_last    = (r_y == (r_len_y - DIM_W'(1)));
    assign o_last      = w_x_last && w_y_last && (r_f == (r_len_f - CH_W'(1)));
    assign o_lane      = LANE_W'(r_elem & ADDR_W'(PACK - 1));
    assign o_same_word = !w_x_last && (o_lane != LANE_W'(PACK - 1));
    assign o_elem      = r_elem;
    assign o_ram_addr  = r_ram_addr;

    // Counter and address registers: load on start, advance one element per step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len_x    <= '0;
            r_len_y    <= '0;
            r_len_f    <= '0;
            r_stride_y <= '0;
            r_stride_f <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_f        <= '0;
            r_elem     <= '0;
            r_row      <= '0;
            r_plane    <= '0;
            r_ram_addr <= '0;
        end else if (i_start) begin
            r_len_x    <= i_len_x;
            r_len_y    <= i_len_y;
            r_len_f    <= i_len_f;
            r_stride_y <= i_stride_y;
            r_stride_f <= i_stride_f;
            r_x        <= '0;
            r_y        <= '0;
            r_f        <= '0;
            r_elem     <= i_base;
            r_row      <= i_base;
            r_plane    <= i_base;
            r_ram_addr <= i_ram_base;
        end else if (i_step) begin
            r_ram_addr <= r_ram_addr + RAM_AW'(1);
            if (!w_x_last) begin
                r_x    <= r_x + DIM_W'(1);
                r_elem <= r_elem + ADDR_W'(1);
            end else if (!w_y_last) begin
                r_x    <= '0;
                r_y    <= r_y + DIM_W'(1);
                r_row  <= r_row + r_stride_y;
                r_elem <= r_row + r_stride_y;
            end else begin
                r_x     <= '0;
                r_y     <= '0;
                r_f     <= r_f + CH_W'(1);
                r_plane <= r_plane + r_stride_f;
                r_row   <= r_plane + r_stride_f;
                r_elem  <= r_plane + r_stride_f;
            end
        end
    end

endmodule

// File: rtl/dma_tile_mover.sv
// 3-D tile DMA between external word memory and an element-wide buffer RAM,
// packing/unpacking elements into words with per-element write enables.
module dma_tile_mover
    import dma_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ELEM_W = 16,
    parameter int ADDR_W = 32,
    parameter int RAM_AW = 16,
    parameter int DIM_W  = 8,
    parameter int CH_W   = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_op,
    input  logic                     dir,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W-1:0]        stride_y,
    input  logic [ADDR_W-1:0]        stride_f,
    input  logic [DIM_W-1:0]         len_x,
    input  logic [DIM_W-1:0]         len_y,
    input  logic [CH_W-1:0]          len_f,
    input  logic [RAM_AW-1:0]        ram_base,
    output logic                     r_request_extmem,
    input  logic                     r_valid_extmem,
    input  logic [DATA_W-1:0]        data_extmem,
    output logic                     w_request_extmem,
    input  logic                     w_ack_extmem,
    output logic [DATA_W-1:0]        w_data_extmem,
    output logic [DATA_W/ELEM_W-1:0] w_be_extmem,
    output logic [ADDR_W-1:0]        addr_extmem,
    output logic [RAM_AW-1:0]        ram_addr,
    output logic [ELEM_W-1:0]        ram_data,
    output logic                     write,
    input  logic [ELEM_W-1:0]        ram_q,
    output logic                     busy,
    output logic                     e_op
);

    localparam int PACK   = DATA_W / ELEM_W;
    localparam int LOG2P  = log2_pack(PACK);
    localparam int LANE_W = (LOG2P > 0) ? LOG2P : 1;

    dma_state_t        r_state, w_next;
    logic [DATA_W-1:0] r_word, r_wdata;
    logic [PACK-1:0]   r_be;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_fin;
    logic              w_start, w_step, w_zero_len;
    logic [ADDR_W-1:0] w_elem;
    logic [RAM_AW-1:0] w_ram_addr;
    logic              w_last, w_same_word;
    logic [LANE_W-1:0] w_lane;

    dma_addr_gen #(
        .ADDR_W (ADDR_W),
        .RAM_AW (RAM_AW),
        .DIM_W  (DIM_W),
        .CH_W   (CH_W),
        .PACK   (PACK),
        .LANE_W (LANE_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start),
        .i_step      (w_step),
        .i_base      (base_addr),
        .i_stride_y  (stride_y),
        .i_stride_f  (stride_f),
        .i_len_x     (len_x),
        .i_len_y     (len_y),
        .i_len_f     (len_f),
        .i_ram_base  (ram_base),
        .o_elem      (w_elem),
        .o_ram_addr  (w_ram_addr),
        .o_last      (w_last),
        .o_same_word (w_same_word),
        .o_lane      (w_lane)
    );

    assign w_zero_len = (len_x == {DIM_W{1'b0}}) || (len_y == {DIM_W{1'b0}}) ||
                        (len_f == {CH_W{1'b0}});

    // A store word's address is frozen at capture, since the walker has moved on.
    assign r_request_extmem = (r_state == S_RD_REQ);
    assign w_request_extmem = (r_state == S_WR_REQ);
    assign w_data_extmem    = r_wdata;
    assign w_be_extmem      = r_be;
    assign addr_extmem      = (r_state == S_WR_REQ) ? r_waddr : (w_elem >> LOG2P);
    assign ram_addr         = w_ram_addr;
    assign write            = (r_state == S_UNPACK);
    assign ram_data         = (r_state == S_UNPACK) ? r_word[w_lane*ELEM_W +: ELEM_W]
                                                    : {ELEM_W{1'b0}};
    assign busy             = (r_state != S_IDLE);
    assign e_op             = (r_state == S_DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus start/step strobes to the address walker.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_step  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (s_op) begin
                    w_start = 1'b1;
                    if (w_zero_len) begin
                        w_next = S_DONE;
                    end else if (dir == DIR_STORE) begin
                        w_next = S_ST_RD;
                    end else begin
                        w_next = S_RD_REQ;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RD_REQ: begin
                if (r_valid_extmem) begin
                    w_next = S_UNPACK;
                end else begin
                    w_next = S_RD_REQ;
                end
            end
            S_UNPACK: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end else if (w_same_word) begin
                    w_next = S_UNPACK;
                end else begin
                    w_next = S_RD_REQ;
                end
            end
            S_ST_RD: begin
                w_next = S_ST_CAP;
            end
            S_ST_CAP: begin
                w_step = 1'b1;
                if (w_same_word && !w_last) begin
                    w_next = S_ST_RD;
                end else begin
                    w_next = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (!w_ack_extmem) begin
                    w_next = S_WR_REQ;
                end else if (r_fin) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_ST_RD;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Word buffers: read-word capture for unpack, lane assembly for store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_waddr <= '0;
            r_fin   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (s_op) begin
                        r_wdata <= '0;
                        r_be    <= '0;
                    end
                end
                S_RD_REQ: begin
                    if (r_valid_extmem) begin
                        r_word <= data_extmem;
                    end
                end
                S_ST_CAP: begin
                    r_wdata[w_lane*ELEM_W +: ELEM_W] <= ram_q;
                    r_be[w_lane]                     <= 1'b1;
                    r_waddr                          <= w_elem >> LOG2P;
                    r_fin                            <= w_last;
                end
                S_WR_REQ: begin
                    if (w_ack_extmem) begin
                        r_wdata <= '0;
                        r_be    <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_tile_mover.sv
// Randomised and directed bench for dma_tile_mover, checked against a
// nested-loop tile model with bench-side memory and RAM responders.
module tb_dma_tile_mover;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_op, dir;
    logic [31:0] base_addr, stride_y, stride_f;
    logic [7:0]  len_x, len_y;
    logic [10:0] len_f;
    logic [15:0] ram_base;
    logic        r_request_extmem, r_valid_extmem;
    logic [31:0] data_extmem;
    logic        w_request_extmem, w_ack_extmem;
    logic [31:0] w_data_extmem;
    logic [1:0]  w_be_extmem;
    logic [31:0] addr_extmem;
    logic [15:0] ram_addr, ram_data, ram_q;
    logic        write, busy, e_op;

    dma_tile_mover dut (
        .clk(clk), .rst(rst), .s_op(s_op), .dir(dir), .base_addr(base_addr),
        .stride_y(stride_y), .stride_f(stride_f), .len_x(len_x), .len_y(len_y),
        .len_f(len_f), .ram_base(ram_base), .r_request_extmem(r_request_extmem),
        .r_valid_extmem(r_valid_extmem), .data_extmem(data_extmem),
        .w_request_extmem(w_request_extmem), .w_ack_extmem(w_ack_extmem),
        .w_data_extmem(w_data_extmem), .w_be_extmem(w_be_extmem),
        .addr_extmem(addr_extmem), .ram_addr(ram_addr), .ram_data(ram_data),
        .write(write), .ram_q(ram_q), .busy(busy), .e_op(e_op)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          wr_cyc_q[$];
    logic [31:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [31:0] st_addr_q[$];
    logic [31:0] st_data_q[$];
    logic [1:0]  st_be_q[$];
    int          st_cyc_q[$];
    int          eop_q[$];
    int          busy_rise_q[$];
    int          unstable = 0;
    int          rd_delay = 0, ack_delay = 0, rd_wait = 0, ack_wait = 0;
    logic        prev_rreq = 1'b0, prev_wreq = 1'b0, prev_busy = 1'b0;
    logic [31:0] held_addr, held_wdata;
    logic [1:0]  held_be;
    logic [15:0] prev_ram_addr = 16'd0;

    // Word w of external memory holds elements 2w and 2w+1 with value (element address + 1).
    function automatic logic [31:0] ext_word(input logic [31:0] w);
        return {16'(2 * w + 2), 16'(2 * w + 1)};
    endfunction

    function automatic logic [15:0] ram_val(input logic [15:0] a);
        return 16'(a * 16'h0131 + 16'h5A5A);
    endfunction

    // Observe outputs mid-cycle, then play external memory and buffer RAM.
    always @(negedge clk) begin
        if (write) begin
            wr_addr_q.push_back(ram_addr);
            wr_data_q.push_back(ram_data);
            wr_cyc_q.push_back(cyc);
        end
        if (e_op) eop_q.push_back(cyc);
        if (busy && !prev_busy) busy_rise_q.push_back(cyc);
        prev_busy = busy;
        if (r_request_extmem) begin
            if (!prev_rreq) begin
                rd_addr_q.push_back(addr_extmem);
                rd_cyc_q.push_back(cyc);
                held_addr = addr_extmem;
                rd_wait   = rd_delay;
            end else if (addr_extmem !== held_addr) begin
                unstable++;
            end
            if (rd_wait == 0) begin
                r_valid_extmem = 1'b1;
                data_extmem    = ext_word(addr_extmem);
            end else begin
                r_valid_extmem = 1'b0;
                rd_wait--;
            end
        end else begin
            r_valid_extmem = 1'b0;
        end
        prev_rreq = r_request_extmem;
        if (w_request_extmem) begin
            if (!prev_wreq) begin
                ack_wait   = ack_delay;
                held_addr  = addr_extmem;
                held_wdata = w_data_extmem;
                held_be    = w_be_extmem;
            end else if (addr_extmem !== held_addr || w_data_extmem !== held_wdata ||
                         w_be_extmem !== held_be) begin
                unstable++;
            end
            if (ack_wait == 0) begin
                if (!w_ack_extmem) begin
                    w_ack_extmem = 1'b1;
                    st_addr_q.push_back(addr_extmem);
                    st_data_q.push_back(w_data_extmem);
                    st_be_q.push_back(w_be_extmem);
                    st_cyc_q.push_back(cyc);
                end
            end else begin
                w_ack_extmem = 1'b0;
                ack_wait--;
            end
        end else begin
            w_ack_extmem = 1'b0;
        end
        prev_wreq     = w_request_extmem;
        ram_q         = ram_val(prev_ram_addr);
        prev_ram_addr = ram_addr;
    end

    task automatic clear_mon();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        rd_addr_q.delete(); rd_cyc_q.delete();
        st_addr_q.delete(); st_data_q.delete(); st_be_q.delete(); st_cyc_q.delete();
        eop_q.delete(); busy_rise_q.delete();
        unstable = 0;
    endtask

    // Issue a command, scramble the command inputs afterwards, wait for completion.
    task automatic issue(input logic d, input logic [31:0] b, input logic [31:0] sy,
                         input logic [31:0] sf, input logic [7:0] lx, input logic [7:0] ly,
                         input logic [10:0] lf, input logic [15:0] rb, input bit poke,
                         output int start_c);
        @(negedge clk); #1;
        clear_mon();
        dir = d; base_addr = b; stride_y = sy; stride_f = sf;
        len_x = lx; len_y = ly; len_f = lf; ram_base = rb; s_op = 1'b1;
        start_c = cyc;
        @(negedge clk); #1;
        s_op = 1'b0; dir = 1'($urandom); base_addr = $urandom; stride_y = $urandom;
        stride_f = $urandom; len_x = 8'($urandom); len_y = 8'($urandom);
        len_f = 11'($urandom); ram_base = 16'($urandom);
        for (int i = 0; i < 3000 && eop_q.size() == 0; i++) begin
            s_op = (poke && i == 2) ? 1'b1 : 1'b0;
            @(negedge clk); #1;
        end
        s_op = 1'b0;
        vectors++;
        if (eop_q.size() == 0) begin
            miscompares++;
            $display("FAIL done_timeout got no e_op expected e_op within 3000 cycles");
        end
        repeat (3) begin @(negedge clk); #1; end
    endtask

    task automatic test_load(input logic [31:0] b, input logic [31:0] sy, input logic [31:0] sf,
                             input logic [7:0] lx, input logic [7:0] ly, input logic [10:0] lf,
                             input logic [15:0] rb, input int dly, input bit poke);
        logic [31:0] e;
        logic [15:0] exp_ra[$];
        logic [15:0] exp_rd[$];
        logic [31:0] exp_rw[$];
        int start_c, k, exp_eop;
        rd_delay = dly;
        issue(1'b0, b, sy, sf, lx, ly, lf, rb, poke, start_c);
        k = 0;
        for (int f = 0; f < int'(lf); f++)
            for (int y = 0; y < int'(ly); y++)
                for (int x = 0; x < int'(lx); x++) begin
                    e = b + 32'(f) * sf + 32'(y) * sy + 32'(x);
                    if (x == 0 || (e % 32'd2) == 32'd0) exp_rw.push_back(e / 32'd2);
                    exp_ra.push_back(16'(rb + 16'(k)));
                    exp_rd.push_back(16'(e + 32'd1));
                    k++;
                end
        vectors++;
        if (eop_q.size() != 1) begin
            miscompares++; $display("FAIL load_eop_count got %0d expected 1", eop_q.size());
        end
        vectors++;
        if (busy_rise_q.size() == 0 || busy_rise_q[0] != start_c + 1) begin
            miscompares++;
            $display("FAIL load_busy_rise got %0d expected %0d",
                     (busy_rise_q.size() == 0) ? -1 : busy_rise_q[0], start_c + 1);
        end
        vectors++;
        if (wr_addr_q.size() != exp_ra.size() || rd_addr_q.size() != exp_rw.size() ||
            st_addr_q.size() != 0) begin
            miscompares++;
            $display("FAIL load_counts got writes=%0d reads=%0d stores=%0d expected %0d %0d 0",
                     wr_addr_q.size(), rd_addr_q.size(), st_addr_q.size(),
                     exp_ra.size(), exp_rw.size());
        end
        for (int i = 0; i < exp_ra.size() && i < wr_addr_q.size(); i++) begin
            vectors++;
            if (wr_addr_q[i] !== exp_ra[i] || wr_data_q[i] !== exp_rd[i]) begin
                miscompares++;
                $display("FAIL load_ram_write[%0d] got addr=%h data=%h expected addr=%h data=%h",
                         i, wr_addr_q[i], wr_data_q[i], exp_ra[i], exp_rd[i]);
            end
        end
        for (int i = 0; i < exp_rw.size() && i < rd_addr_q.size(); i++) begin
            vectors++;
            if (rd_addr_q[i] !== exp_rw[i]) begin
                miscompares++;
                $display("FAIL load_read_addr[%0d] got %h expected %h", i, rd_addr_q[i], exp_rw[i]);
            end
        end
        if (exp_rw.size() > 0 && rd_cyc_q.size() > 0) begin
            vectors++;
            if (rd_cyc_q[0] != start_c + 1) begin
                miscompares++;
                $display("FAIL load_first_req_cycle got %0d expected %0d", rd_cyc_q[0], start_c + 1);
            end
        end
        exp_eop = (wr_cyc_q.size() > 0) ? wr_cyc_q[wr_cyc_q.size() - 1] + 1 : start_c + 1;
        vectors++;
        if (eop_q.size() == 0 || eop_q[0] != exp_eop) begin
            miscompares++;
            $display("FAIL load_eop_cycle got %0d expected %0d",
                     (eop_q.size() == 0) ? -1 : eop_q[0], exp_eop);
        end
        vectors++;
        if (unstable != 0) begin
            miscompares++; $display("FAIL load_addr_stable got %0d changes expected 0", unstable);
        end
    endtask

    task automatic test_store(input logic [31:0] b, input logic [31:0] sy, input logic [31:0] sf,
                              input logic [7:0] lx, input logic [7:0] ly, input logic [10:0] lf,
                              input logic [15:0] rb, input int dly);
        logic [31:0] e, ga, gd, mask;
        logic [1:0]  gb;
        logic [31:0] exp_a[$];
        logic [31:0] exp_d[$];
        logic [1:0]  exp_b[$];
        int start_c, k, lane, exp_eop;
        bit have_g;
        ack_delay = dly;
        issue(1'b1, b, sy, sf, lx, ly, lf, rb, 1'b0, start_c);
        k = 0; have_g = 0; ga = '0; gd = '0; gb = '0;
        for (int f = 0; f < int'(lf); f++)
            for (int y = 0; y < int'(ly); y++)
                for (int x = 0; x < int'(lx); x++) begin
                    e = b + 32'(f) * sf + 32'(y) * sy + 32'(x);
                    lane = int'(e % 32'd2);
                    if (have_g && (x == 0 || lane == 0)) begin
                        exp_a.push_back(ga); exp_d.push_back(gd); exp_b.push_back(gb);
                        have_g = 0;
                    end
                    if (!have_g) begin
                        ga = e / 32'd2; gd = '0; gb = '0; have_g = 1;
                    end
                    gd[lane*16 +: 16] = ram_val(16'(rb + 16'(k)));
                    gb[lane] = 1'b1;
                    k++;
                end
        if (have_g) begin
            exp_a.push_back(ga); exp_d.push_back(gd); exp_b.push_back(gb);
        end
        vectors++;
        if (eop_q.size() != 1) begin
            miscompares++; $display("FAIL store_eop_count got %0d expected 1", eop_q.size());
        end
        vectors++;
        if (st_addr_q.size() != exp_a.size() || wr_addr_q.size() != 0 || rd_addr_q.size() != 0) begin
            miscompares++;
            $display("FAIL store_counts got stores=%0d writes=%0d reads=%0d expected %0d 0 0",
                     st_addr_q.size(), wr_addr_q.size(), rd_addr_q.size(), exp_a.size());
        end
        for (int i = 0; i < exp_a.size() && i < st_addr_q.size(); i++) begin
            mask = {{16{st_be_q[i][1]}}, {16{st_be_q[i][0]}}};
            vectors++;
            if (st_addr_q[i] !== exp_a[i] || st_be_q[i] !== exp_b[i] ||
                (st_data_q[i] & mask) !== exp_d[i]) begin
                miscompares++;
                $display("FAIL store_word[%0d] got addr=%h be=%b data=%h expected addr=%h be=%b data=%h",
                         i, st_addr_q[i], st_be_q[i], st_data_q[i], exp_a[i], exp_b[i], exp_d[i]);
            end
        end
        exp_eop = (st_cyc_q.size() > 0) ? st_cyc_q[st_cyc_q.size() - 1] + 1 : start_c + 1;
        vectors++;
        if (eop_q.size() == 0 || eop_q[0] != exp_eop) begin
            miscompares++;
            $display("FAIL store_eop_cycle got %0d expected %0d",
                     (eop_q.size() == 0) ? -1 : eop_q[0], exp_eop);
        end
        vectors++;
        if (unstable != 0) begin
            miscompares++; $display("FAIL store_req_stable got %0d changes expected 0", unstable);
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({busy, e_op, r_request_extmem, w_request_extmem, write} !== 5'b0 ||
            ram_addr !== 16'd0 || addr_extmem !== 32'd0 || w_be_extmem !== 2'b00 ||
            w_data_extmem !== 32'd0 || ram_data !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_values got busy=%b eop=%b rreq=%b wreq=%b wr=%b ra=%h ea=%h be=%b expected all zero",
                     busy, e_op, r_request_extmem, w_request_extmem, write, ram_addr, addr_extmem, w_be_extmem);
        end
    endtask

    task automatic test_aligned_load();
        test_load(32'd0, 32'd4, 32'd0, 8'd4, 8'd2, 11'd1, 16'd0, 0, 1'b0);
        vectors++;
        if (wr_data_q.size() != 8 || wr_data_q[7] !== 16'd8) begin
            miscompares++; $display("FAIL aligned_last_elem got size=%0d expected 8 elements ending 0008", wr_data_q.size());
        end
    endtask

    task automatic test_unaligned_load();
        test_load(32'd1, 32'd16, 32'd0, 8'd3, 8'd1, 11'd1, 16'h0010, 1, 1'b0);
        vectors++;
        if (wr_data_q.size() == 0 || wr_data_q[0] !== 16'h0002 || rd_addr_q.size() != 2) begin
            miscompares++; $display("FAIL unaligned_first_elem got reads=%0d expected upper half 0002 and 2 reads", rd_addr_q.size());
        end
    endtask

    task automatic test_store_partial();
        test_store(32'd1, 32'd8, 32'd0, 8'd4, 8'd1, 11'd1, 16'h0020, 0);
        vectors++;
        if (st_be_q.size() != 3 || st_be_q[0] !== 2'b10 || st_be_q[1] !== 2'b11 || st_be_q[2] !== 2'b01) begin
            miscompares++; $display("FAIL partial_enables got %0d words expected be 10,11,01", st_be_q.size());
        end
    endtask

    task automatic test_zero_and_ignored();
        test_load(32'd5, 32'd4, 32'd0, 8'd3, 8'd2, 11'd0, 16'd0, 0, 1'b0);
        test_store(32'd5, 32'd4, 32'd0, 8'd0, 8'd2, 11'd1, 16'd0, 0);
        test_load(32'd6, 32'd8, 32'd0, 8'd4, 8'd3, 11'd1, 16'd0, 2, 1'b1);
    endtask

    task automatic test_multichannel_stall();
        test_load(32'd0, 32'd10, 32'd100, 8'd2, 8'd2, 11'd2, 16'd0, 3, 1'b0);
        vectors++;
        if (rd_addr_q.size() < 3 || rd_addr_q[2] !== 32'd50) begin
            miscompares++; $display("FAIL plane2_word got reads=%0d expected third read at word 50", rd_addr_q.size());
        end
    endtask

    task automatic test_reset_mid_store();
        bit seen;
        int start_c;
        seen = 0;
        ack_delay = 6;
        @(negedge clk); #1;
        clear_mon();
        dir = 1'b1; base_addr = 32'd0; stride_y = 32'd0; stride_f = 32'd0;
        len_x = 8'd2; len_y = 8'd1; len_f = 11'd1; ram_base = 16'd0; s_op = 1'b1;
        start_c = cyc;
        @(negedge clk); #1;
        s_op = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (w_request_extmem) seen = 1;
            else begin @(negedge clk); #1; end
        end
        vectors++;
        if (!seen) begin
            miscompares++; $display("FAIL reset_wr_req_reached got none expected WR_REQ after cycle %0d", start_c);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (w_request_extmem !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid_op got wreq=%b busy=%b expected 0 0", w_request_extmem, busy);
        end
        @(negedge clk); #1;
        rst = 1'b0;
        test_store(32'd3, 32'd20, 32'd0, 8'd3, 8'd2, 11'd1, 16'h0100, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            test_load($urandom, 32'($urandom_range(0, 40)), $urandom,
                      8'($urandom_range(1, 5)), 8'($urandom_range(1, 3)), 11'($urandom_range(1, 2)),
                      16'($urandom), $urandom_range(0, 3), 1'($urandom));
            test_store($urandom, $urandom, 32'($urandom_range(0, 60)),
                       8'($urandom_range(1, 5)), 8'($urandom_range(1, 3)), 11'($urandom_range(1, 2)),
                       16'($urandom), $urandom_range(0, 3));
        end
    endtask

    initial begin
        rst = 1'b1; s_op = 1'b0; dir = 1'b0; base_addr = '0; stride_y = '0; stride_f = '0;
        len_x = '0; len_y = '0; len_f = '0; ram_base = '0;
        r_valid_extmem = 1'b0; data_extmem = '0; w_ack_extmem = 1'b0; ram_q = '0;
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_aligned_load();
        test_unaligned_load();
        test_store_partial();
        test_zero_and_ignored();
        test_multichannel_stall();
        test_reset_mid_store();
        test_load(32'hFFFF_FFFD, 32'd3, 32'd0, 8'd3, 8'd2, 11'd1, 16'hFFFE, 1, 1'b0);
        test_store(32'hFFFF_FFFF, 32'd2, 32'd0, 8'd3, 8'd2, 11'd1, 16'hFFFD, 0);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
